// File: rtl/axi_riscv_lrsc_pkg.sv
// Shared types for the LR/SC reservation controller: table entry layout,
// SC verdict FSM states and the granule-tag width helper.
package axi_riscv_lrsc_pkg;

  // Entries carry a full-width tag field; narrower tags are zero-extended.
  localparam int unsigned TAG_W_MAX = 64;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
  } resv_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } sc_state_e;

  function automatic int unsigned tag_width(input int unsigned addr_w,
                                            input int unsigned gran_bytes);
    return addr_w - $clog2(gran_bytes);
  endfunction

endpackage

// File: rtl/axi_riscv_lrsc_resv_entry.sv
// One reservation slot: a write to the same granule clears it, an SC on this
// ID clears it, and an LR on this ID sets it (last step wins).
module axi_riscv_lrsc_resv_entry
  import axi_riscv_lrsc_pkg::*;
#(
  parameter int unsigned TAG_W = 61
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             set_i,
  input  logic [TAG_W-1:0] set_tag_i,
  input  logic             clr_sc_i,
  input  logic             wr_valid_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [TAG_W-1:0] sc_tag_i,
  output logic             valid_o,
  output logic             valid_next_o,
  output logic             sc_match_o
);

  resv_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (wr_valid_i && entry_q.valid && (entry_q.tag == TAG_W_MAX'(wr_tag_i))) begin
      entry_d.valid = 1'b0;
    end
    if (clr_sc_i) begin
      entry_d.valid = 1'b0;
    end
    if (set_i) begin
      entry_d.valid = 1'b1;
      entry_d.tag   = TAG_W_MAX'(set_tag_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign valid_o      = entry_q.valid;
  assign valid_next_o = entry_d.valid;
  assign sc_match_o   = entry_q.valid && (entry_q.tag == TAG_W_MAX'(sc_tag_i));

endmodule

// File: rtl/axi_riscv_lrsc_resv_ctrl.sv
// LR/SC reservation table with one entry per AXI ID and a registered SC
// pass/fail verdict delivered over a valid/ready handshake.
module axi_riscv_lrsc_resv_ctrl
  import axi_riscv_lrsc_pkg::*;
#(
  parameter int unsigned                AXI_ADDR_WIDTH  = 64,
  parameter int unsigned                AXI_ID_WIDTH    = 4,
  parameter int unsigned                RESV_GRAN_BYTES = 8,
  parameter logic [AXI_ADDR_WIDTH-1:0]  ADDR_BEGIN      = 64'h0000_0000_0000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0]  ADDR_END        = 64'h0000_7fff_ffff_ffff
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      lr_valid_i,
  output logic                      lr_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] lr_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   lr_id_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic                      sc_valid_i,
  output logic                      sc_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] sc_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   sc_id_i,
  output logic                      sc_resp_valid_o,
  input  logic                      sc_resp_ready_i,
  output logic                      sc_resp_ok_o,
  output logic [AXI_ID_WIDTH-1:0]   sc_resp_id_o,
  output logic [AXI_ID_WIDTH:0]     resv_cnt_o,
  output logic                      sc_state_o
);

  // Handshakes: a transfer happens on a rising clk_i edge where valid and
  // ready are both high; valid never waits for ready, and the verdict
  // (ok, id) stays stable while sc_resp_valid_o is high and ready is low.

  localparam int unsigned GRAN_LOG = $clog2(RESV_GRAN_BYTES);
  localparam int unsigned TAG_W    = tag_width(AXI_ADDR_WIDTH, RESV_GRAN_BYTES);
  localparam int unsigned N_ENTRY  = 2 ** AXI_ID_WIDTH;
  localparam int unsigned CNT_W    = AXI_ID_WIDTH + 1;

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    return (a >= ADDR_BEGIN) && (a <= ADDR_END);
  endfunction

  logic [TAG_W-1:0] lr_tag, wr_tag, sc_tag;
  logic             lr_in_range, sc_in_range;
  logic             sc_hs, wr_hits_sc, sc_ok;
  logic             unused_wr_low;

  logic [N_ENTRY-1:0] entry_valid, entry_valid_next, entry_sc_match;

  sc_state_e         state_q, state_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_ok_q, resp_ok_d;
  logic [AXI_ID_WIDTH-1:0] resp_id_q, resp_id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign lr_tag = lr_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG];
  assign wr_tag = wr_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG];
  assign sc_tag = sc_addr_i[AXI_ADDR_WIDTH-1:GRAN_LOG];

  // Byte-offset bits of a write never matter: invalidation is per granule.
  assign unused_wr_low = ^wr_addr_i;

  assign lr_in_range = in_range(lr_addr_i);
  assign sc_in_range = in_range(sc_addr_i);

  assign lr_ready_o = 1'b1;
  assign wr_ready_o = 1'b1;
  assign sc_ready_o = (state_q == IDLE);
  assign sc_hs      = sc_valid_i && sc_ready_o;

  // A write to the SC's granule in the same cycle beats the SC.
  assign wr_hits_sc = wr_valid_i && (wr_tag == sc_tag);
  assign sc_ok      = sc_in_range && entry_sc_match[sc_id_i] && !wr_hits_sc;

  for (genvar g = 0; g < N_ENTRY; g++) begin : g_entry
    axi_riscv_lrsc_resv_entry #(
      .TAG_W(TAG_W)
    ) u_entry (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .set_i       (lr_valid_i && lr_in_range && (lr_id_i == AXI_ID_WIDTH'(g))),
      .set_tag_i   (lr_tag),
      .clr_sc_i    (sc_hs && (sc_id_i == AXI_ID_WIDTH'(g))),
      .wr_valid_i  (wr_valid_i),
      .wr_tag_i    (wr_tag),
      .sc_tag_i    (sc_tag),
      .valid_o     (entry_valid[g]),
      .valid_next_o(entry_valid_next[g]),
      .sc_match_o  (entry_sc_match[g])
    );
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < N_ENTRY; i++) begin
      cnt_d = cnt_d + CNT_W'(entry_valid_next[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_ok_d    = resp_ok_q;
    resp_id_d    = resp_id_q;
    case (state_q)
      IDLE: begin
        if (sc_hs) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_ok_d    = sc_ok;
          resp_id_d    = sc_id_i;
        end
      end
      RESP: begin
        if (sc_resp_ready_i) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
      resp_ok_q    <= 1'b0;
      resp_id_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_ok_q    <= resp_ok_d;
      resp_id_q    <= resp_id_d;
      cnt_q        <= cnt_d;
    end
  end

  assign sc_resp_valid_o = resp_valid_q;
  assign sc_resp_ok_o    = resp_ok_q;
  assign sc_resp_id_o    = resp_id_q;
  assign resv_cnt_o      = cnt_q;
  assign sc_state_o      = state_q;

  logic unused_entry_valid;
  assign unused_entry_valid = ^entry_valid;

endmodule

// File: tb/tb_axi_riscv_lrsc_resv_ctrl.sv
// Bench for the LR/SC reservation controller: directed scenarios with literal
// expectations plus a randomized run compared every cycle to a reference model.
module tb_axi_riscv_lrsc_resv_ctrl;

  localparam logic [63:0] ADDR_END_C = 64'h0000_7fff_ffff_ffff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        lr_valid, wr_valid, sc_valid, sc_resp_ready;
  logic [63:0] lr_addr, wr_addr, sc_addr;
  logic [3:0]  lr_id, sc_id;
  logic        lr_ready, wr_ready, sc_ready, sc_resp_valid, sc_resp_ok, sc_state;
  logic [3:0]  sc_resp_id;
  logic [4:0]  resv_cnt;

  axi_riscv_lrsc_resv_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .lr_valid_i     (lr_valid),
    .lr_ready_o     (lr_ready),
    .lr_addr_i      (lr_addr),
    .lr_id_i        (lr_id),
    .wr_valid_i     (wr_valid),
    .wr_ready_o     (wr_ready),
    .wr_addr_i      (wr_addr),
    .sc_valid_i     (sc_valid),
    .sc_ready_o     (sc_ready),
    .sc_addr_i      (sc_addr),
    .sc_id_i        (sc_id),
    .sc_resp_valid_o(sc_resp_valid),
    .sc_resp_ready_i(sc_resp_ready),
    .sc_resp_ok_o   (sc_resp_ok),
    .sc_resp_id_o   (sc_resp_id),
    .resv_cnt_o     (resv_cnt),
    .sc_state_o     (sc_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_v[16];
  logic [63:0] m_t[16];
  logic        m_pend, m_ok;
  logic [3:0]  m_id;
  int          m_cnt;

  function automatic logic rng(input logic [63:0] a);
    return a <= ADDR_END_C;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic hs, okv;
    logic [63:0] sct;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        m_v[i] = 1'b0;
        m_t[i] = '0;
      end
      m_pend = 1'b0; m_ok = 1'b0; m_id = '0; m_cnt = 0;
    end else begin
      hs  = sc_valid && !m_pend;
      sct = sc_addr >> 3;
      okv = rng(sc_addr) && m_v[sc_id] && (m_t[sc_id] == sct) &&
            !(wr_valid && ((wr_addr >> 3) == sct));
      if (hs) begin
        m_pend = 1'b1; m_ok = okv; m_id = sc_id;
      end else if (m_pend && sc_resp_ready) begin
        m_pend = 1'b0;
      end
      if (wr_valid)
        for (int i = 0; i < 16; i++)
          if (m_t[i] == (wr_addr >> 3)) m_v[i] = 1'b0;
      if (hs) m_v[sc_id] = 1'b0;
      if (lr_valid && rng(lr_addr)) begin
        m_v[lr_id] = 1'b1;
        m_t[lr_id] = lr_addr >> 3;
      end
      m_cnt = 0;
      for (int i = 0; i < 16; i++) m_cnt += int'(m_v[i]);
    end
  end

  // ---------------- per-cycle scoreboard compare ----------------
  always @(posedge clk) begin
    #1;
    check("cmp_resp_valid", sc_resp_valid, m_pend);
    check("cmp_sc_ready", sc_ready, !m_pend);
    check("cmp_cnt", resv_cnt, m_cnt);
    check("cmp_tied_ready", {lr_ready, wr_ready}, 2'b11);
    if (m_pend) begin
      check("cmp_resp_ok", sc_resp_ok, m_ok);
      check("cmp_resp_id", sc_resp_id, m_id);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    lr_valid = 0; wr_valid = 0; sc_valid = 0;
    lr_addr = '0; wr_addr = '0; sc_addr = '0; lr_id = '0; sc_id = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_lr(input logic [3:0] id, input logic [63:0] a);
    @(negedge clk);
    clear_inputs();
    lr_valid = 1; lr_id = id; lr_addr = a;
    step();
    @(negedge clk);
    lr_valid = 0;
  endtask

  task automatic do_wr(input logic [63:0] a);
    @(negedge clk);
    clear_inputs();
    wr_valid = 1; wr_addr = a;
    step();
    @(negedge clk);
    wr_valid = 0;
  endtask

  task automatic do_sc(input string name, input logic [3:0] id, input logic [63:0] a,
                       input logic wr_en, input logic [63:0] wa, input logic exp_ok);
    @(negedge clk);
    clear_inputs();
    sc_resp_ready = 1;
    sc_valid = 1; sc_id = id; sc_addr = a;
    wr_valid = wr_en; wr_addr = wa;
    step();
    check({name, "_valid"}, sc_resp_valid, 1'b1);
    check({name, "_ok"}, sc_resp_ok, exp_ok);
    check({name, "_id"}, sc_resp_id, id);
    @(negedge clk);
    clear_inputs();
    step();
    check({name, "_drain"}, sc_resp_valid, 1'b0);
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] bases[5];
    bases[0] = 64'h1000; bases[1] = 64'h1008; bases[2] = 64'h2000;
    bases[3] = 64'h0000_8000_0000_0000; bases[4] = 64'h0000_7fff_ffff_fff8;
    return bases[$urandom_range(0, 4)] + 64'($urandom_range(0, 7));
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    clear_inputs();
    sc_resp_ready = 1;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cnt", resv_cnt, 5'd0);
    check("rst_resp_valid", sc_resp_valid, 1'b0);
    check("rst_resp_ok", sc_resp_ok, 1'b0);
    check("rst_resp_id", sc_resp_id, 4'd0);
    @(negedge clk) rst_n = 1;
    step();
    check("post_rst_sc_ready", sc_ready, 1'b1);

    // reservation and single use
    do_lr(4'd3, 64'h1000);
    check("lr3_cnt", resv_cnt, 5'd1);
    @(negedge clk);
    sc_valid = 1; sc_id = 4'd3; sc_addr = 64'h1004;
    step();
    check("sc3_valid", sc_resp_valid, 1'b1);
    check("sc3_ok", sc_resp_ok, 1'b1);
    check("sc3_id", sc_resp_id, 4'd3);
    check("sc3_cnt", resv_cnt, 5'd0);
    check("sc3_ready_low", sc_ready, 1'b0);
    @(negedge clk) clear_inputs();
    step();
    do_sc("sc3_again", 4'd3, 64'h1000, 1'b0, '0, 1'b0);

    // write invalidation across IDs
    do_lr(4'd1, 64'h2000);
    do_lr(4'd2, 64'h2000);
    check("lr12_cnt", resv_cnt, 5'd2);
    do_wr(64'h2007);
    check("wr_clear_cnt", resv_cnt, 5'd0);
    do_sc("sc2_after_wr", 4'd2, 64'h2000, 1'b0, '0, 1'b0);

    // same-cycle race with a write
    do_lr(4'd5, 64'h3000);
    do_sc("sc5_race", 4'd5, 64'h3000, 1'b1, 64'h3000, 1'b0);
    do_lr(4'd5, 64'h3000);
    do_sc("sc5_other", 4'd5, 64'h3000, 1'b1, 64'h3008, 1'b1);

    // out-of-range LR and SC
    do_lr(4'd0, 64'h0000_8000_0000_0000);
    check("oor_cnt", resv_cnt, 5'd0);
    do_sc("sc0_oor", 4'd0, 64'h0000_8000_0000_0000, 1'b0, '0, 1'b0);

    // backpressure on the verdict, LR accepted meanwhile
    do_lr(4'd4, 64'h4000);
    check("lr4_cnt", resv_cnt, 5'd1);
    @(negedge clk);
    sc_resp_ready = 0;
    sc_valid = 1; sc_id = 4'd4; sc_addr = 64'h4000;
    step();
    check("bp_valid0", sc_resp_valid, 1'b1);
    check("bp_ok0", sc_resp_ok, 1'b1);
    check("bp_cnt0", resv_cnt, 5'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      clear_inputs();
      lr_valid = (k == 1); lr_id = 4'd7; lr_addr = 64'h7000;
      step();
      check("bp_hold_valid", sc_resp_valid, 1'b1);
      check("bp_hold_ok", sc_resp_ok, 1'b1);
      check("bp_hold_id", sc_resp_id, 4'd4);
      check("bp_hold_ready", sc_ready, 1'b0);
      check("bp_hold_cnt", resv_cnt, (k >= 1) ? 5'd1 : 5'd0);
    end
    @(negedge clk);
    clear_inputs();
    sc_resp_ready = 1;
    step();
    check("bp_release_valid", sc_resp_valid, 1'b0);
    check("bp_release_ready", sc_ready, 1'b1);

    // reset while a verdict is pending
    @(negedge clk);
    sc_resp_ready = 0;
    sc_valid = 1; sc_id = 4'd7; sc_addr = 64'h7000;
    lr_valid = 1; lr_id = 4'd9; lr_addr = 64'h9000;
    step();
    check("mid_valid", sc_resp_valid, 1'b1);
    check("mid_ok", sc_resp_ok, 1'b1);
    check("mid_cnt", resv_cnt, 5'd1);
    #2 rst_n = 0;
    #1;
    check("mid_rst_valid", sc_resp_valid, 1'b0);
    check("mid_rst_cnt", resv_cnt, 5'd0);
    @(negedge clk);
    clear_inputs();
    sc_resp_ready = 1;
    rst_n = 1;
    step();
    check("mid_rst_ready", sc_ready, 1'b1);

    // randomized traffic against the model
    repeat (3000) begin
      @(negedge clk);
      lr_valid      = ($urandom_range(0, 3) == 0);
      lr_id         = 4'($urandom_range(0, 3));
      lr_addr       = rand_addr();
      wr_valid      = ($urandom_range(0, 5) == 0);
      wr_addr       = rand_addr();
      sc_valid      = ($urandom_range(0, 2) == 0);
      sc_id         = 4'($urandom_range(0, 3));
      sc_addr       = rand_addr();
      sc_resp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    clear_inputs();
    sc_resp_ready = 1;
    repeat (3) step();
    check("final_drain", sc_resp_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
